// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: tick-paced 0..MAX_LEVEL amplitude with a registered stage and level.
// Define ADSR_HARD_RETRIGGER_EN to restart each attack from 0; otherwise a retrigger is legato.
module adsr_envelope #(
    parameter int RATE_W    = 12,
    parameter int MAX_LEVEL = 100
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic              gate_i,
    input  logic [RATE_W-1:0] attack_i,
    input  logic [RATE_W-1:0] decay_i,
    input  logic [6:0]        sustain_i,
    input  logic [RATE_W-1:0] release_i,
    output logic [6:0]        env_level_o,
    output logic [2:0]        env_stage_o,
    output logic              env_active_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } stage_e;

    localparam logic [6:0] LVL_MAX = 7'(MAX_LEVEL);

    stage_e            stage_q, stage_d;
    logic [6:0]        level_q, level_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic              gate_q;
    logic              active_q, active_d;

    logic              rise;
    logic              fall;
    logic [6:0]        tgt;
    logic [RATE_W-1:0] rate;
    logic              step_due;

    assign rise = gate_i & ~gate_q;
    assign fall = ~gate_i & gate_q;
    assign tgt  = (sustain_i > LVL_MAX) ? LVL_MAX : sustain_i;

    always_comb begin
        rate = '0;
        case (stage_q)
            ST_ATTACK:  rate = attack_i;
            ST_DECAY:   rate = decay_i;
            ST_RELEASE: rate = release_i;
            default:    rate = '0;
        endcase
    end

    // >= rather than == so a rate lowered mid-stage steps at once instead of wrapping cnt.
    assign step_due = (cnt_q >= rate);

    always_comb begin
        stage_d = stage_q;
        level_d = level_q;
        cnt_d   = cnt_q;

        if (rise) begin
            stage_d = ST_ATTACK;
            cnt_d   = '0;
`ifdef ADSR_HARD_RETRIGGER_EN
            level_d = '0;
`endif
        end else if (fall && (stage_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
            stage_d = ST_RELEASE;
            cnt_d   = '0;
        end else if (tick_i) begin
            case (stage_q)
                ST_ATTACK: begin
                    if (level_q >= LVL_MAX) begin
                        stage_d = ST_DECAY;
                        cnt_d   = '0;
                    end else if (step_due) begin
                        cnt_d   = '0;
                        level_d = level_q + 7'd1;
                        if (level_q + 7'd1 == LVL_MAX)
                            stage_d = ST_DECAY;
                    end else begin
                        cnt_d = cnt_q + RATE_W'(1);
                    end
                end
                ST_DECAY: begin
                    if (level_q <= tgt) begin
                        stage_d = ST_SUSTAIN;
                        cnt_d   = '0;
                    end else if (step_due) begin
                        cnt_d   = '0;
                        level_d = level_q - 7'd1;
                        if (level_q - 7'd1 == tgt)
                            stage_d = ST_SUSTAIN;
                    end else begin
                        cnt_d = cnt_q + RATE_W'(1);
                    end
                end
                ST_SUSTAIN: begin
                    // Follow live sustain edits as a jump, not a ramp.
                    level_d = tgt;
                    cnt_d   = '0;
                end
                ST_RELEASE: begin
                    if (level_q == 7'd0) begin
                        stage_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (step_due) begin
                        cnt_d   = '0;
                        level_d = level_q - 7'd1;
                        if (level_q == 7'd1)
                            stage_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + RATE_W'(1);
                    end
                end
                default: begin
                    stage_d = ST_IDLE;
                    level_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        active_d = (stage_d != ST_IDLE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stage_q  <= ST_IDLE;
            level_q  <= '0;
            cnt_q    <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            gate_q   <= gate_i;
            active_q <= active_d;
        end
    end

    assign env_level_o  = level_q;
    assign env_stage_o  = stage_q;
    assign env_active_o = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed envelope scenarios plus randomized gate/tick/rate traffic
// compared every cycle against a stage-table model of the envelope.
module tb_adsr_envelope;

    localparam int MAXL = 100;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
`ifdef ADSR_HARD_RETRIGGER_EN
    localparam bit HARD = 1'b1;
`else
    localparam bit HARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        gate;
    logic [11:0] attack;
    logic [11:0] decay;
    logic [6:0]  sustain;
    logic [11:0] rel_rate;
    logic [6:0]  env_level;
    logic [2:0]  env_stage;
    logic        env_active;

    int n_checks = 0;
    int n_pass   = 0;

    int m_level = 0;
    int m_stage = S_IDLE;
    int m_cnt   = 0;
    bit m_gd    = 1'b0;

    always #5 clk = ~clk;

    adsr_envelope #(.RATE_W(12), .MAX_LEVEL(MAXL)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .tick_i      (tick),
        .gate_i      (gate),
        .attack_i    (attack),
        .decay_i     (decay),
        .sustain_i   (sustain),
        .release_i   (rel_rate),
        .env_level_o (env_level),
        .env_stage_o (env_stage),
        .env_active_o(env_active)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // One clock of the envelope, described per stage as (rate, destination, direction, next stage).
    task automatic model_step();
        bit rise, fall, at_dest;
        int tgt, rate, dest, dir, nxt;
        if (rst) begin
            m_level = 0; m_stage = S_IDLE; m_cnt = 0; m_gd = 1'b0;
            return;
        end
        rise = gate && !m_gd;
        fall = !gate && m_gd;
        m_gd = gate;
        tgt  = (int'(sustain) > MAXL) ? MAXL : int'(sustain);
        if (rise) begin
            m_stage = S_ATT; m_cnt = 0;
            if (HARD) m_level = 0;
        end else if (fall && m_stage >= S_ATT && m_stage <= S_SUS) begin
            m_stage = S_REL; m_cnt = 0;
        end else if (tick) begin
            if (m_stage == S_IDLE) begin
                m_level = 0; m_cnt = 0;
            end else if (m_stage == S_SUS) begin
                m_level = tgt;
            end else begin
                rate    = (m_stage == S_ATT) ? int'(attack) : (m_stage == S_DEC) ? int'(decay) : int'(rel_rate);
                dest    = (m_stage == S_ATT) ? MAXL : (m_stage == S_DEC) ? tgt : 0;
                dir     = (m_stage == S_ATT) ? 1 : -1;
                nxt     = (m_stage == S_ATT) ? S_DEC : (m_stage == S_DEC) ? S_SUS : S_IDLE;
                at_dest = (dir > 0) ? (m_level >= dest) : (m_level <= dest);
                if (at_dest) begin
                    m_stage = nxt; m_cnt = 0;
                end else if (m_cnt >= rate) begin
                    m_cnt   = 0;
                    m_level = m_level + dir;
                    if (m_level == dest) m_stage = nxt;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        chk("model_level", int'(env_level), m_level);
        chk("model_stage", int'(env_stage), m_stage);
        chk("model_active", int'(env_active), int'(m_stage != S_IDLE));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_state(input string nm, input int lvl, input int stg);
        chk({nm, "_level"}, int'(env_level), lvl);
        chk({nm, "_stage"}, int'(env_stage), stg);
        chk({nm, "_active"}, int'(env_active), int'(stg != S_IDLE));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        attack = 12'd0; decay = 12'd0; sustain = 7'd60; rel_rate = 12'd1;
        cyc(2);
        expect_state("reset", 0, S_IDLE);

        // Fast attack to peak, decay to 60.
        rst = 1'b0; tick = 1'b1; gate = 1'b1;
        cyc(1);   expect_state("att_start", 0, S_ATT);
        cyc(99);  expect_state("att_99", 99, S_ATT);
        cyc(1);   expect_state("att_peak", 100, S_DEC);
        cyc(39);  expect_state("dec_61", 61, S_DEC);
        cyc(1);   expect_state("dec_sus", 60, S_SUS);

        // Release at one step per 2 ticks.
        gate = 1'b0;
        cyc(1);   expect_state("rel_start", 60, S_REL);
        cyc(60);  expect_state("rel_60", 30, S_REL);
        cyc(59);  expect_state("rel_119", 1, S_REL);
        cyc(1);   expect_state("rel_idle", 0, S_IDLE);

        // Retrigger during release at level 40.
        gate = 1'b1;
        cyc(141); expect_state("sus_again", 60, S_SUS);
        gate = 1'b0;
        cyc(41);  expect_state("rel_40", 40, S_REL);
        gate = 1'b1;
        cyc(1);   expect_state("retrig", HARD ? 0 : 40, S_ATT);
        tick = 1'b0;
        cyc(5);   expect_state("no_tick", HARD ? 0 : 40, S_ATT);
        tick = 1'b1;
        cyc(1);   expect_state("retrig_step", HARD ? 1 : 41, S_ATT);

        // Reset with gate held: rise seen right after reset; slow attack.
        rst = 1'b1;
        cyc(1);   expect_state("rst_gate_hi", 0, S_IDLE);
        rst = 1'b0; attack = 12'd3;
        cyc(1);   expect_state("rst_rise", 0, S_ATT);
        cyc(100); expect_state("att3_100", 25, S_ATT);

        // Sustain clamp, then live sustain edit.
        attack = 12'd0; sustain = 7'd127;
        cyc(75);  expect_state("clamp_peak", 100, S_DEC);
        cyc(1);   expect_state("clamp_sus", 100, S_SUS);
        sustain = 7'd20;
        cyc(1);   expect_state("sus_edit", 20, S_SUS);

        // Reset in the middle of an attack at level 50.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);   expect_state("att2_start", 0, S_ATT);
        cyc(50);  expect_state("att2_50", 50, S_ATT);
        rst = 1'b1;
        cyc(1);   expect_state("mid_reset", 0, S_IDLE);
        rst = 1'b0;
        cyc(1);   expect_state("post_reset", 0, S_ATT);

        // Randomized traffic, checked by the per-cycle model.
        for (int i = 0; i < 6000; i++) begin
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) < 2) gate = ~gate;
            if ($urandom_range(0, 63) == 0) begin
                attack   = 12'($urandom_range(0, 2));
                decay    = 12'($urandom_range(0, 3));
                rel_rate = 12'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) == 0) sustain = 7'($urandom_range(0, 127));
            rst = ($urandom_range(0, 1999) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR envelope generator; sits directly downstream of the synthesizer parameter-state block.
- Consumes the ADSR attack, decay, sustain and release settings and a key gate.
- Produces a 7-bit amplitude level (0..MAX_LEVEL) that the voice/VCA stage multiplies with oscillator output.
- Steps are paced by a sample-rate tick strobe, not the raw clock.

Parameters:
- RATE_W, 12, width of the attack/decay/release rate inputs and of the internal tick counter.
- MAX_LEVEL, 100, peak envelope level; matches the 0..100 volume/sustain scale.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- tick  in  1  one-cycle sample-rate enable; envelope advances only on cycles with tick=1.
- gate  in  1  key held (1) / released (0); level-sensitive, edges detected internally.
- attack  in  RATE_W  ticks per +1 step in ATTACK, minus 1.
- decay  in  RATE_W  ticks per −1 step in DECAY, minus 1.
- sustain  in  7  sustain level; values >MAX_LEVEL are clamped to MAX_LEVEL.
- release  in  RATE_W  ticks per −1 step in RELEASE, minus 1.
- env_level  out  7  current envelope level, registered.
- env_stage  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, registered.
- env_active  out  1  1 when env_stage≠IDLE, registered.

Behaviour:
- Reset values:
  - env_level=0, env_stage=IDLE, env_active=0.
  - Tick counter cnt=0; gate_d (registered gate) = 0.
  - If gate is held high through reset, the first cycle after reset sees a rising edge.
- Edge detect: rise = gate & ~gate_d; fall = ~gate & gate_d; gate_d updates every clock regardless of tick.
- Edge priority: edges act on the cycle they are seen, independent of tick, and pre-empt any tick step that cycle.
  - rise: any state → ATTACK, cnt←0.
  - fall: ATTACK/DECAY/SUSTAIN → RELEASE, cnt←0; ignored in IDLE and RELEASE.
- Stage result is visible on env_stage the next cycle.
- Rate stepping (ATTACK, DECAY, RELEASE) on tick with no edge:
  - If cnt ≥ rate: cnt←0 and take one level step.
  - Otherwise cnt←cnt+1.
  - Use ≥, not ==, so that lowering a rate mid-stage never causes a counter wrap.
  - Rate=0 gives one step per tick.
- Sustain target: tgt = min(sustain, MAX_LEVEL).
- ATTACK:
  - Step is level+1. When the new level equals MAX_LEVEL → DECAY, cnt←0.
  - If level ≥ MAX_LEVEL on a tick → DECAY immediately, level unchanged.
- DECAY:
  - If level ≤ tgt on a tick → SUSTAIN, level unchanged.
  - Otherwise step is level−1; when the new level equals tgt → SUSTAIN.
- SUSTAIN: on each tick level←tgt, so live sustain edits take effect (jump, not ramp). Stays until fall.
- RELEASE:
  - If level=0 on a tick → IDLE.
  - Otherwise step is level−1; when the new level is 0 → IDLE, cnt←0.
- IDLE: level held at 0, cnt held at 0.
- No wrap-around: level never exceeds MAX_LEVEL and never goes below 0.
- tick=0: no state or level change except edge handling.
- Reset mid-stage: the next cycle is the IDLE/0 state, regardless of gate.

Optional Feature:
- Macro: ADSR_HARD_RETRIGGER_EN.
- Defined: a rise also forces env_level←0 in the same cycle, so every note starts its attack from silence.
- Undefined: a rise keeps the current env_level and the attack resumes from it (legato retrigger, no click).

Test Plan:
- attack=0, decay=0, sustain=60, gate held 1, tick every cycle:
  - env_level reaches 100 exactly 100 ticks after the ATTACK stage begins, with stage=DECAY.
  - Level reaches 60 40 ticks later, with stage=SUSTAIN.
- attack=3, tick every cycle: level increments once per 4 ticks; level=25 after 100 ticks in ATTACK.
- In SUSTAIN at 60, release=1, gate→0: RELEASE, level decrements once per 2 ticks, IDLE with env_active=0 after 120 ticks.
- Gate re-pressed in RELEASE at level 40:
  - Without the macro: ATTACK continues from 40.
  - With ADSR_HARD_RETRIGGER_EN: level=0 the next cycle.
- sustain=127 with decay=0: clamped, so DECAY→SUSTAIN on the first tick at 100. Then change sustain to 20 in SUSTAIN: level=20 on the next tick.
- Assert reset during ATTACK at level 50 with gate=1: level=0 and IDLE the next cycle. After reset release, a rise is detected and ATTACK starts.
